// File: rtl/calc_entry_ctrl_pkg.sv
// Shared definitions for the calculator entry path: key codes, ALU op encodings
// and the entry controller state encoding.
package calc_defs;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_EXEC    = 3'd2,
        S_WAIT    = 3'd3,
        S_STORE   = 3'd4,
        S_ERR     = 3'd5
    } state_e;

    function automatic logic is_digit_key(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op_key(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_key_event_detect.sv
// Turns a level key_push into a single-cycle event; push_q resets high so a key
// already held when reset releases never produces an event.
module key_event_detect (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key_digit,
    input  logic       i_key_push,
    output logic       o_event,
    output logic [3:0] o_key
);

    logic r_push_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_push_q <= 1'b1;
        end else begin
            r_push_q <= i_key_push;
        end
    end

    assign o_event = i_key_push & ~r_push_q;
    assign o_key   = i_key_digit;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU sequencer: BCD operand entry, operator selection, ALU start/done
// handshake with timeout, and circular result history writes.
module calc_entry_ctrl #(
    parameter int NDIG    = 4,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [3:0]          i_key_digit,
    input  logic                i_key_push,
    output logic [4*NDIG-1:0]   o_alu_a,
    output logic [4*NDIG-1:0]   o_alu_b,
    output logic [1:0]          o_alu_op,
    output logic                o_alu_start,
    input  logic                i_alu_done,
    input  logic [4*NDIG-1:0]   i_alu_result,
    input  logic                i_alu_err,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [4*NDIG-1:0]   o_mem_wdata,
    output logic [4*NDIG-1:0]   o_disp_value,
    output logic                o_busy,
    output logic                o_error,
    output logic [2:0]          o_dbg_state
);

    import calc_defs::*;

    localparam int W     = 4 * NDIG;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic             w_event;
    logic [3:0]       w_key;
    logic             w_clr;
    logic             w_digit;
    logic             w_op_key;
    logic [1:0]       w_key_op;

    state_e           r_state,    w_state_nxt;
    logic [W-1:0]     r_a,        w_a_nxt;
    logic [W-1:0]     r_b,        w_b_nxt;
    logic [CNT_W-1:0] r_cnt_a,    w_cnt_a_nxt;
    logic [CNT_W-1:0] r_cnt_b,    w_cnt_b_nxt;
    logic [1:0]       r_op,       w_op_nxt;
    logic             r_res_flag, w_res_flag_nxt;
    logic [ADDR_W-1:0] r_wr_ptr,  w_wr_ptr_nxt;
    logic [TMO_W-1:0] r_tmo,      w_tmo_nxt;

    key_event_detect u_key (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_key_digit (i_key_digit),
        .i_key_push  (i_key_push),
        .o_event     (w_event),
        .o_key       (w_key)
    );

    assign w_digit  = w_event && is_digit_key(w_key);
    assign w_op_key = w_event && is_op_key(w_key);
    assign w_key_op = 2'(w_key - KEY_ADD);
    // Clear is honoured only in the entry states and ERR; busy states drop it.
    assign w_clr    = w_event && (w_key == KEY_CLR) &&
                      (r_state == S_ENTER_A || r_state == S_ENTER_B || r_state == S_ERR);

    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_cnt_a_nxt    = r_cnt_a;
        w_cnt_b_nxt    = r_cnt_b;
        w_op_nxt       = r_op;
        w_res_flag_nxt = r_res_flag;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_tmo_nxt      = r_tmo;

        if (w_clr) begin
            w_state_nxt    = S_ENTER_A;
            w_a_nxt        = '0;
            w_b_nxt        = '0;
            w_cnt_a_nxt    = '0;
            w_cnt_b_nxt    = '0;
            w_op_nxt       = '0;
            w_res_flag_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ENTER_A: begin
                    if (w_digit) begin
                        if (r_res_flag) begin
                            // A still holds the last result: the first digit starts a fresh operand.
                            w_a_nxt        = W'(w_key);
                            w_cnt_a_nxt    = CNT_W'(1);
                            w_res_flag_nxt = 1'b0;
                        end else if (r_cnt_a != CNT_W'(NDIG)) begin
                            w_a_nxt     = {r_a[W-5:0], w_key};
                            w_cnt_a_nxt = r_cnt_a + CNT_W'(1);
                        end
                    end else if (w_op_key) begin
                        w_op_nxt    = w_key_op;
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_state_nxt = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (w_digit) begin
                        if (r_cnt_b != CNT_W'(NDIG)) begin
                            w_b_nxt     = {r_b[W-5:0], w_key};
                            w_cnt_b_nxt = r_cnt_b + CNT_W'(1);
                        end
                    end else if (w_op_key) begin
                        if (r_cnt_b == '0) begin
                            w_op_nxt = w_key_op;
                        end
                    end else if (w_event && w_key == KEY_EQ && r_cnt_b != '0) begin
                        w_state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // A done pulse takes priority over the timeout firing on the same cycle.
                    if (i_alu_done && !i_alu_err) begin
                        w_a_nxt     = i_alu_result;
                        w_cnt_a_nxt = CNT_W'(NDIG);
                        w_state_nxt = S_STORE;
                    end else if (i_alu_done) begin
                        w_state_nxt = S_ERR;
                    end else if (r_tmo == TMO_W'(TIMEOUT)) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_tmo_nxt = r_tmo + TMO_W'(1);
                    end
                end
                S_STORE: begin
                    w_wr_ptr_nxt   = r_wr_ptr + ADDR_W'(1);
                    w_res_flag_nxt = 1'b1;
                    w_state_nxt    = S_ENTER_A;
                end
                S_ERR: begin
                    w_state_nxt = S_ERR;
                end
                default: begin
                    w_state_nxt = S_ENTER_A;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_ENTER_A;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_op       <= '0;
            r_res_flag <= 1'b0;
            r_wr_ptr   <= '0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_cnt_a    <= w_cnt_a_nxt;
            r_cnt_b    <= w_cnt_b_nxt;
            r_op       <= w_op_nxt;
            r_res_flag <= w_res_flag_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_tmo      <= w_tmo_nxt;
        end
    end

    // ALU handshake: start is a one-cycle pulse in EXEC; operands hold until WAIT exits.
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_alu_op     = r_op;
    assign o_alu_start  = (r_state == S_EXEC);
    assign o_mem_we     = (r_state == S_STORE);
    assign o_mem_addr   = r_wr_ptr;
    assign o_mem_wdata  = (r_state == S_STORE) ? r_a : '0;
    assign o_busy       = (r_state == S_EXEC) || (r_state == S_WAIT) || (r_state == S_STORE);
    assign o_error      = (r_state == S_ERR);
    assign o_dbg_state  = r_state;
    assign o_disp_value = (r_state == S_ERR) ? {NDIG{4'hE}} :
                          (r_state == S_ENTER_B && r_cnt_b != '0) ? r_b : r_a;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key entry, ALU handshake, timeout,
// error recovery, reset abort and history pointer wrap.
module tb_calc_entry_ctrl;

    localparam logic [2:0] ST_A     = 3'd0;
    localparam logic [2:0] ST_B     = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        key_push = 1'b0;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0;
    logic        alu_err = 1'b0;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] disp_value;
    logic        busy, error;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int we_cnt = 0;

    calc_entry_ctrl #(.NDIG(4), .ADDR_W(3), .TIMEOUT(255)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_digit  (key_digit),
        .i_key_push   (key_push),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_alu_start  (alu_start),
        .i_alu_done   (alu_done),
        .i_alu_result (alu_result),
        .i_alu_err    (alu_err),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_disp_value (disp_value),
        .o_busy       (busy),
        .o_error      (error),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alu_start) start_cnt++;
        if (mem_we) we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_push = 1'b1;
        tick();
        key_push = 1'b0;
        tick();
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] exp_disp);
        chk({tag, " state"}, 32'(dbg_state), 32'(ST_A));
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " disp"}, 32'(disp_value), 32'(exp_disp));
    endtask

    function automatic logic [15:0] bcd(input int v);
        bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Press '=' from ENTER_B and complete one successful ALU transaction.
    task automatic run_op(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                          input logic [1:0] eop, input logic [15:0] res, input logic [2:0] eaddr);
        int s0, w0;
        s0 = start_cnt;
        w0 = we_cnt;
        key_digit = 4'd14;
        key_push = 1'b1;
        tick();
        chk({tag, " exec state"}, 32'(dbg_state), 32'(ST_EXEC));
        chk({tag, " alu_start"}, 32'(alu_start), 32'd1);
        chk({tag, " alu_a"}, 32'(alu_a), 32'(ea));
        chk({tag, " alu_b"}, 32'(alu_b), 32'(eb));
        chk({tag, " alu_op"}, 32'(alu_op), 32'(eop));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        key_push = 1'b0;
        tick();
        chk({tag, " wait state"}, 32'(dbg_state), 32'(ST_WAIT));
        chk({tag, " start low"}, 32'(alu_start), 32'd0);
        chk({tag, " alu_a hold"}, 32'(alu_a), 32'(ea));
        alu_done = 1'b1;
        alu_result = res;
        tick();
        alu_done = 1'b0;
        alu_result = 16'h0;
        chk({tag, " store state"}, 32'(dbg_state), 32'(ST_STORE));
        chk({tag, " mem_we"}, 32'(mem_we), 32'd1);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(eaddr));
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(res));
        tick();
        chk_idle({tag, " after"}, res);
        chk({tag, " mem_we low"}, 32'(mem_we), 32'd0);
        chk({tag, " one start"}, 32'(start_cnt), 32'(s0 + 1));
        chk({tag, " one we"}, 32'(we_cnt), 32'(w0 + 1));
    endtask

    initial begin
        int n_to;
        int s0, w0;

        // Reset state
        tick();
        tick();
        chk_idle("reset", 16'h0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_b", 32'(alu_b), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset start", 32'(alu_start), 32'd0);
        chk("reset mem", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 12 + 3 = 15
        press(4'd1);
        chk("t1 disp 1", 32'(disp_value), 32'h0001);
        press(4'd2);
        chk("t1 disp 12", 32'(disp_value), 32'h0012);
        press(4'd10);
        chk("t1 enter_b", 32'(dbg_state), 32'(ST_B));
        chk("t1 disp A while b empty", 32'(disp_value), 32'h0012);
        press(4'd3);
        chk("t1 disp B", 32'(disp_value), 32'h0003);
        run_op("t1", 16'h0012, 16'h0003, 2'd0, 16'h0015, 3'd0);

        // 2: long hold yields a single event
        press(4'd15);
        chk_idle("t2 clr", 16'h0);
        key_digit = 4'd7;
        key_push = 1'b1;
        repeat (50) tick();
        key_push = 1'b0;
        tick();
        chk("t2 held", 32'(disp_value), 32'h0007);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        chk("t2 cnt_a was 1", 32'(disp_value), 32'h7123);
        press(4'd4);
        chk("t2 full", 32'(disp_value), 32'h7123);

        // 3: fifth digit ignored
        press(4'd15);
        for (int k = 1; k <= 5; k++) press(4'(k));
        chk("t3 A", 32'(disp_value), 32'h1234);
        chk("t3 error", 32'(error), 32'd0);

        // ENTER_A '=' ignored, op replace rules, '=' with empty B ignored
        press(4'd15);
        press(4'd3);
        s0 = start_cnt;
        press(4'd14);
        chk("eqA ignored state", 32'(dbg_state), 32'(ST_A));
        press(4'd10);
        press(4'd12);
        press(4'd14);
        chk("eqB empty state", 32'(dbg_state), 32'(ST_B));
        chk("eq ignored no start", 32'(start_cnt), 32'(s0));
        press(4'd4);
        press(4'd11);
        chk("op after digit ignored", 32'(alu_op), 32'd2);
        run_op("mul", 16'h0003, 16'h0004, 2'd2, 16'h0012, 3'd1);

        // 4: timeout, keys ignored while busy, recovery by clear
        press(4'd15);
        press(4'd2);
        press(4'd11);
        press(4'd1);
        s0 = start_cnt;
        w0 = we_cnt;
        key_digit = 4'd14;
        key_push = 1'b1;
        tick();
        chk("t4 exec", 32'(dbg_state), 32'(ST_EXEC));
        key_push = 1'b0;
        n_to = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 10) begin
                key_digit = 4'd15;
                key_push = 1'b1;
            end
            if (i == 11) key_push = 1'b0;
            if (i == 20) begin
                chk("t4 clr ignored busy", 32'(dbg_state), 32'(ST_WAIT));
                chk("t4 alu_a stable", 32'(alu_a), 32'h0002);
                chk("t4 alu_op stable", 32'(alu_op), 32'd1);
            end
            if (error) begin
                n_to = i;
                break;
            end
        end
        chk("t4 timeout cycles", 32'(n_to), 32'd257);
        chk("t4 err state", 32'(dbg_state), 32'(ST_ERR));
        chk("t4 disp E", 32'(disp_value), 32'hEEEE);
        chk("t4 busy", 32'(busy), 32'd0);
        chk("t4 one start", 32'(start_cnt), 32'(s0 + 1));
        chk("t4 no we", 32'(we_cnt), 32'(w0));
        press(4'd5);
        chk("t4 key ignored in err", 32'(dbg_state), 32'(ST_ERR));
        press(4'd15);
        chk_idle("t4 clr", 16'h0);
        chk("t4 A cleared", 32'(alu_a), 32'd0);

        // done on the same cycle the timeout would fire wins
        press(4'd4);
        press(4'd10);
        press(4'd5);
        key_digit = 4'd14;
        key_push = 1'b1;
        tick();
        key_push = 1'b0;
        repeat (256) tick();
        chk("edge still waiting", 32'(dbg_state), 32'(ST_WAIT));
        alu_done = 1'b1;
        alu_result = 16'h0009;
        tick();
        alu_done = 1'b0;
        alu_result = 16'h0;
        chk("edge store", 32'(dbg_state), 32'(ST_STORE));
        chk("edge mem_addr", 32'(mem_addr), 32'd2);
        chk("edge wdata", 32'(mem_wdata), 32'h0009);
        tick();
        chk_idle("edge after", 16'h0009);

        // ALU error response
        press(4'd15);
        press(4'd5);
        press(4'd13);
        press(4'd0);
        w0 = we_cnt;
        key_digit = 4'd14;
        key_push = 1'b1;
        tick();
        key_push = 1'b0;
        tick();
        chk("aerr wait", 32'(dbg_state), 32'(ST_WAIT));
        alu_done = 1'b1;
        alu_err = 1'b1;
        alu_result = 16'h1234;
        tick();
        alu_done = 1'b0;
        alu_err = 1'b0;
        alu_result = 16'h0;
        chk("aerr state", 32'(dbg_state), 32'(ST_ERR));
        chk("aerr error", 32'(error), 32'd1);
        chk("aerr disp", 32'(disp_value), 32'hEEEE);
        tick();
        chk("aerr no we", 32'(we_cnt), 32'(w0));
        press(4'd3);
        chk("aerr digit ignored", 32'(dbg_state), 32'(ST_ERR));
        press(4'd15);
        chk_idle("aerr clr", 16'h0);

        // 6: reset during WAIT aborts cleanly
        press(4'd6);
        press(4'd10);
        press(4'd7);
        key_digit = 4'd14;
        key_push = 1'b1;
        tick();
        key_push = 1'b0;
        repeat (3) tick();
        chk("t6 wait", 32'(dbg_state), 32'(ST_WAIT));
        s0 = start_cnt;
        w0 = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6 async state", 32'(dbg_state), 32'(ST_A));
        chk("t6 async busy", 32'(busy), 32'd0);
        chk("t6 async alu_a", 32'(alu_a), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        alu_done = 1'b1;
        alu_result = 16'h0013;
        tick();
        alu_done = 1'b0;
        alu_result = 16'h0;
        tick();
        chk_idle("t6 after", 16'h0);
        chk("t6 no we", 32'(we_cnt), 32'(w0));
        chk("t6 no start", 32'(start_cnt), 32'(s0));
        chk("t6 outputs", 32'({alu_a, alu_b}), 32'd0);
        chk("t6 op/mem", 32'({alu_op, alu_start, mem_we, mem_addr, mem_wdata}), 32'd0);

        // 5: nine chained operations, history pointer wraps 7 -> 0
        press(4'd1);
        press(4'd10);
        press(4'd1);
        run_op("t5 op0", 16'h0001, 16'h0001, 2'd0, bcd(2), 3'd0);
        for (int i = 1; i <= 8; i++) begin
            press(4'd10);
            press(4'd1);
            run_op($sformatf("t5 op%0d", i), bcd(i + 1), 16'h0001, 2'd0, bcd(i + 2), 3'(i % 8));
        end
        press(4'd9);
        chk("t5 digit after result", 32'(disp_value), 32'h0009);
        press(4'd8);
        chk("t5 second digit", 32'(disp_value), 32'h0098);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
